// File: rtl/register_snapshot_reader.sv
// Per-frame register snapshot engine: on each vblank rising edge it walks the
// CPU register file over a req/ack port, fills a shadow buffer and commits all
// registers to the display bus in a single edge.
module register_snapshot_reader #(
  parameter int unsigned NUM_REGS = 11,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vblank,
  output logic                      rd_req,
  output logic [3:0]                rd_addr,
  input  logic                      rd_ack,
  input  logic [WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*WIDTH-1:0] registers,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      error
);

  localparam int unsigned BusW   = NUM_REGS * WIDTH;
  localparam int unsigned TimerW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LastIdx = 4'(NUM_REGS - 1);
  // Timer counts REQ cycles already spent; the request gives up at the end of
  // the TIMEOUT-th waiting cycle unless ack arrives in that same cycle.
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StNext,
    StCommit
  } state_e;

  state_e              state_q, state_d;
  logic                vblank_dly_q, vblank_dly_d;
  logic [3:0]          idx_q, idx_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [BusW-1:0]     shadow_q, shadow_d;
  logic [BusW-1:0]     registers_q, registers_d;
  logic                rd_req_q, rd_req_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;

  logic vblank_rise;
  logic vblank_fall;

  assign vblank_rise = vblank & ~vblank_dly_q;
  assign vblank_fall = ~vblank & vblank_dly_q;

  // Next-state logic for the snapshot walk, shadow capture and commit.
  always_comb begin
    state_d      = state_q;
    vblank_dly_d = vblank;
    idx_d        = idx_q;
    timer_d      = timer_q;
    shadow_d     = shadow_q;
    registers_d  = registers_q;
    rd_req_d     = rd_req_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    error_d      = error_q;

    unique case (state_q)
      StIdle: begin
        // Rising edges while busy never reach here, so they are ignored.
        if (vblank_rise) begin
          idx_d    = '0;
          rd_req_d = 1'b1;
          busy_d   = 1'b1;
          timer_d  = '0;
          state_d  = StReq;
        end
      end

      StReq: begin
        if (vblank_fall) begin
          // Abort beats a same-cycle ack: the frame is no longer consistent.
          error_d  = 1'b1;
          rd_req_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else if (rd_ack) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 4'(i)) begin
              shadow_d[BusW-1-i*WIDTH -: WIDTH] = rd_data;
            end
          end
          rd_req_d = 1'b0;
          state_d  = StNext;
        end else if (timer_q == TimerLast) begin
          error_d  = 1'b1;
          rd_req_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StNext: begin
        if (vblank_fall) begin
          error_d  = 1'b1;
          rd_req_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else if (idx_q == LastIdx) begin
          // frame_done is high for exactly the COMMIT cycle.
          frame_done_d = 1'b1;
          state_d      = StCommit;
        end else begin
          idx_d    = idx_q + 4'd1;
          rd_req_d = 1'b1;
          timer_d  = '0;
          state_d  = StReq;
        end
      end

      StCommit: begin
        registers_d = shadow_q;
        busy_d      = 1'b0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      vblank_dly_q <= 1'b0;
      idx_q        <= '0;
      timer_q      <= '0;
      shadow_q     <= '0;
      registers_q  <= '0;
      rd_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vblank_dly_q <= vblank_dly_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      shadow_q     <= shadow_d;
      registers_q  <= registers_d;
      rd_req_q     <= rd_req_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  // rd_addr simply tracks the walk index; it holds while rd_req is low.
  assign rd_req     = rd_req_q;
  assign rd_addr    = idx_q;
  assign registers  = registers_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_register_snapshot_reader.sv
// Scoreboard bench for register_snapshot_reader: a register-file responder
// with random wait states, expected snapshots queued at stimulus time and a
// monitor that compares the bus after every frame_done.
module tb_register_snapshot_reader;

  localparam int NR = 11;
  localparam int W  = 16;
  localparam int BW = NR * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          vblank;
  logic          rd_req;
  logic [3:0]    rd_addr;
  logic          rd_ack;
  logic [W-1:0]  rd_data;
  logic [BW-1:0] registers;
  logic          frame_done;
  logic          busy;
  logic          error;

  always #5 clk = ~clk;

  register_snapshot_reader #(
    .NUM_REGS(NR),
    .WIDTH   (W),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vblank    (vblank),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .registers (registers),
    .frame_done(frame_done),
    .busy      (busy),
    .error     (error)
  );

  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] sb[$];
  logic [W-1:0]  mem[16];
  int            max_delay = 0;
  int            withhold_addr = -1;
  bit            spurious_en = 1'b0;
  bit            proto_en = 1'b0;
  int            addr_log[$];
  int            fd_count = 0;
  logic [BW-1:0] last_bus = '0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: register n of the snapshot is simply mem[n], r0 at the top.
  function automatic logic [BW-1:0] expected_bus();
    logic [BW-1:0] b;
    b = '0;
    for (int n = 0; n < NR; n++) b[BW-1-W*n -: W] = mem[n];
    return b;
  endfunction

  task automatic load_mem(input bit fixed);
    for (int n = 0; n < 16; n++) mem[n] = fixed ? 16'(32'h1000 + n) : 16'($urandom);
  endtask

  task automatic wait_frame_done(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #2;
      if (frame_done) begin
        cycles = c;
        return;
      end
    end
  endtask

  task automatic wait_req_addr(input int addr, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (rd_req && rd_addr == 4'(addr)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // One low cycle, then a rising vblank; vblank is left high on return.
  task automatic raise_vblank();
    @(posedge clk); #2; vblank = 1'b0;
    @(posedge clk); #2; vblank = 1'b1;
  endtask

  task automatic run_snapshot(input string name, output int cycles);
    sb.push_back(expected_bus());
    raise_vblank();
    wait_frame_done(400, cycles);
    if (cycles < 0) begin
      errors++; checks++;
      $display("FAIL %s_frame_done: got none expected pulse within 400 cycles", name);
    end else begin
      @(posedge clk); #2;
      last_bus = expected_bus();
      check({name, "_busy"}, busy, 0);
    end
  endtask

  // Register-file responder plus req/ack protocol checks.
  initial begin
    int wait_cnt, cur_delay, p1, p2, acked;
    rd_ack = 1'b0; rd_data = '0;
    wait_cnt = 0; cur_delay = 0; p1 = -1; p2 = -1;
    forever begin
      @(posedge clk); #1;
      if (proto_en && !rst) begin
        if (p1 >= 0) check("req_drop_after_ack", rd_req, 0);
        if (p2 >= 0 && p2 < NR - 1) begin
          check("req_after_one_idle", rd_req, 1);
          check("next_rd_addr", rd_addr, p2 + 1);
        end
      end
      acked = -1;
      rd_ack = 1'b0;
      rd_data = 16'($urandom);
      if (rst || !rd_req) begin
        wait_cnt = 0;
        cur_delay = $urandom_range(max_delay, 0);
        if (!rst && spurious_en && $urandom_range(3, 0) == 0) rd_ack = 1'b1;
      end else if (int'(rd_addr) != withhold_addr) begin
        if (wait_cnt >= cur_delay) begin
          rd_ack = 1'b1;
          rd_data = mem[rd_addr];
          addr_log.push_back(int'(rd_addr));
          acked = int'(rd_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      p2 = p1;
      p1 = acked;
    end
  end

  // Monitor: every frame_done must match a queued snapshot, checked next cycle.
  initial begin
    logic [BW-1:0] exp;
    forever begin
      @(posedge clk); #1;
      if (frame_done) begin
        fd_count++;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_frame_done: got pulse expected none, bus %h", registers);
        end else begin
          exp = sb.pop_front();
          @(posedge clk); #1;
          check("snapshot_bus", registers, exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc, fd0, n;
    bit  ok;
    rst = 1'b1; vblank = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_registers", registers, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // Zero-wait acks, fixed pattern, latency and address order.
    load_mem(1'b1);
    max_delay = 0;
    addr_log.delete();
    sb.push_back(expected_bus());
    @(posedge clk); #2; vblank = 1'b1;
    wait_frame_done(100, cyc);
    check("zero_wait_latency", cyc, 23);
    @(posedge clk); #2;
    last_bus = expected_bus();
    check("r0_slice", registers[175:160], 16'h1000);
    check("r10_slice", registers[15:0], 16'h100A);
    check("addr_log_len", addr_log.size(), NR);
    for (int i = 0; i < NR && i < addr_log.size(); i++) check("rd_addr_seq", addr_log[i], i);

    // Random data with 0..5 wait states and spurious acks outside REQ.
    max_delay = 5; spurious_en = 1'b1; proto_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_mem(1'b0);
      run_snapshot("var_wait", cyc);
      check("var_wait_error", error, 0);
    end
    proto_en = 1'b0;

    // Held vblank: one snapshot only until vblank falls and rises again.
    load_mem(1'b0);
    fd0 = fd_count;
    run_snapshot("held", cyc);
    repeat (100) @(posedge clk);
    #2;
    check("held_single_frame_done", fd_count - fd0, 1);
    check("held_idle_busy", busy, 0);
    load_mem(1'b0);
    run_snapshot("held_rearm", cyc);

    // Early vblank end after r5 is captured: abort, no commit.
    load_mem(1'b0);
    raise_vblank();
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk); #2;
      if (rd_ack && rd_req && rd_addr == 4'd5) ok = 1'b1;
    end
    check("early_saw_r5_ack", ok, 1);
    @(posedge clk); #2; vblank = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("early_error", error, 1);
    check("early_busy", busy, 0);
    check("early_rd_req", rd_req, 0);
    check("early_bus_kept", registers, last_bus);
    load_mem(1'b0);
    run_snapshot("after_early", cyc);
    check("error_sticky", error, 1);

    // Reset during r7's request clears everything asynchronously.
    load_mem(1'b0);
    raise_vblank();
    wait_req_addr(7, 200, ok);
    check("reset_saw_r7_req", ok, 1);
    rst = 1'b1;
    #1;
    check("midrst_registers", registers, 0);
    check("midrst_rd_req", rd_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_error", error, 0);
    last_bus = '0;
    vblank = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    load_mem(1'b0);
    run_snapshot("after_reset", cyc);

    // Timeout on r3: 15 waiting cycles, then error and no commit.
    load_mem(1'b0);
    withhold_addr = 3;
    raise_vblank();
    wait_req_addr(3, 200, ok);
    check("timeout_saw_r3_req", ok, 1);
    n = 1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      if (!rd_req) break;
      n++;
    end
    check("timeout_wait_cycles", n, 15);
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_bus_kept", registers, last_bus);
    withhold_addr = -1;
    repeat (5) @(posedge clk);
    #2; vblank = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
